// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-digit seven-segment scan scheduler with blanking and frame snapshot
// Optional blink support is compiled in when DISPLAY_SCAN_BLINK_EN is defined.
module display_scan_ctrl #(
  parameter int DIV          = 100000,
  parameter int BLANK        = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  blink_mask,
  output logic [2:0]  digit_sel,
  output logic [7:0]  anode,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic        frame_start
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic          slot_end;
  logic          frame_end;
  logic [31:0]   sh_digits;
  logic [7:0]    sh_dp;
  logic [7:0]    sh_en;
  logic          blink_dark;
  logic          lit;
  logic [7:0]    anode_d;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit_sel == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      digit_sel <= 3'd0;
    end else if (slot_end) begin
      cnt       <= '0;
      digit_sel <= digit_sel + 3'd1;
    end else begin
      cnt       <= cnt + CW'(1);
    end
  end

  // Inputs are only sampled on the last edge of a frame so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_digits <= 32'd0;
      sh_dp     <= 8'd0;
      sh_en     <= 8'd0;
    end else if (frame_end) begin
      sh_digits <= digits_in;
      sh_dp     <= dp_in;
      sh_en     <= digit_en;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [7:0]    sh_blink;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_blink    <= 8'd0;
    end else if (frame_end) begin
      sh_blink <= blink_mask;
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + FW'(1);
      end
    end
  end

  assign blink_dark = blink_phase & sh_blink[digit_sel];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_dark   = 1'b0;
`endif

  // Drive is registered, so the last slot cycle is excluded to keep the next slot's first cycle dark.
  always_comb begin
    lit     = 1'b0;
    anode_d = 8'hFF;
    if ((cnt >= CNT_BLANK) && !slot_end && sh_en[digit_sel] && !blink_dark) begin
      lit     = 1'b1;
      anode_d = ~(8'b1 << digit_sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode       <= 8'hFF;
      nibble      <= 4'd0;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_d;
      nibble      <= sh_digits[{digit_sel, 2'b00} +: 4];
      dp          <= sh_dp[digit_sel] & lit;
      frame_start <= frame_end;
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scheduler for the 8-digit common-anode seven-segment display. Sequences the digit index (0 = right, 7 = left) at a programmable slot rate, inserts an all-off blanking gap before each digit to suppress ghosting, and supplies the selected digit's nibble and decimal point to the segment decoder. Inputs are snapshotted once per frame so the display never tears; per-digit enable and blink masks are applied here.

## Interface
- `DIV`, 100000: clock cycles per digit slot; legal range BLANK+2 … 2^24.
- `BLANK`, 1000: dead cycles at the start of each slot, all anodes off; legal range 1 … DIV-2.
- `BLINK_FRAMES`, 64: frames per blink half-period; minimum 1.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `digits_in` in 32: eight hex nibbles; nibble k = bits [4k+3:4k] = digit k.
- `dp_in` in 8: decimal point per digit, 1 = lit.
- `digit_en` in 8: 1 = digit k may light.
- `blink_mask` in 8: 1 = digit k blinks (only with `DISPLAY_SCAN_BLINK_EN`).
- `digit_sel` out 3: current slot index; this is the refresh counter.
- `anode` out 8: active-low anode drive; at most one bit low.
- `nibble` out 4: shadowed nibble of the displayed digit, for the decoder.
- `dp` out 1: shadowed dp of the displayed digit.
- `frame_start` out 1: one-cycle pulse when a new frame begins (sel 7→0).

## Operation
- Slot counter `cnt` runs 0…DIV-1. At `cnt==DIV-1`, `cnt`→0 and `digit_sel`→`digit_sel+1` mod 8, wrapping 7→0.
- Two phases per slot:
  - **BLANK** (`cnt < BLANK`): anode target 8'hFF.
  - **ON** (`cnt ≥ BLANK`): anode target is the one-hot-low of `digit_sel` if `sh_en[sel]` is set and the digit is not blinked off; otherwise 8'hFF.
- Frame snapshot happens on the edge where `cnt==DIV-1 && digit_sel==7`:
  - `digits_in`, `dp_in`, `digit_en` and `blink_mask` load into the shadow registers.
  - `frame_start` is 1 for exactly the following cycle, the first cycle of slot 0.
- Input changes at any other time have no effect until the next snapshot.
- `nibble` = `sh_digits[4·sel+3:4·sel]` and `dp` = `sh_dp[sel] & lit`, both registered.
- Blink: a frame counter increments on each snapshot. On reaching BLINK_FRAMES-1 it wraps to 0 and toggles `blink_phase`. When `blink_phase==1`, digits with `sh_blink[k]==1` are held dark and their dp is held at 0.
- Reset values:
  - `cnt`, `digit_sel`, frame counter, `blink_phase`, all shadows: 0.
  - `anode`: 8'hFF.
  - `nibble`, `dp`, `frame_start`: 0.
- Because shadows reset to 0, the first frame after reset is dark. The display first lights in frame 1, starting 8·DIV cycles after reset release.
- Reset asserted mid-slot: `anode` goes to 8'hFF immediately, asynchronously. The scan restarts at slot 0, `cnt` 0 on the first edge after release.

## Timing
- `digit_sel` and `cnt` are registers. `anode`, `nibble` and `dp` are registered from them with one cycle of lag.
- Since BLANK ≥ 1, the lagged `anode` is always 8'hFF in the first cycle of every slot. There is never overlap between adjacent digits.
- Per slot: `anode` is 8'hFF for cycles 0…BLANK of the slot (BLANK+1 cycles). The digit is lit for cycles BLANK+1…DIV-1 (DIV-BLANK-1 cycles).
- Frame period is exactly 8·DIV cycles. `frame_start` period is 8·DIV cycles.
- Snapshot-to-display latency: data sampled on the wrap edge appears on `nibble` when slot 0 lights, BLANK+1 cycles later.
- Blink half-period is BLINK_FRAMES·8·DIV cycles. `blink_phase` toggles in the same cycle `frame_start` is high.

## Configuration
- `DISPLAY_SCAN_BLINK_EN` defined:
  - Frame counter, `blink_phase` and `sh_blink` are present.
  - `blink_mask` behaves as described above.
- `DISPLAY_SCAN_BLINK_EN` not defined:
  - No blink logic is compiled; `blink_mask` is ignored and left unconnected internally.
  - Enabled digits are always lit in their ON phase.

## Test plan
All scenarios use DIV=8, BLANK=2, BLINK_FRAMES=2 unless stated.
- **Reset:** assert `rst` mid-ON-phase → `anode`=FF, `nibble`=0, `dp`=0 and `frame_start`=0 in the same cycle. After release, `digit_sel` steps 0→1 after 8 edges.
- **Scan order:** `digits_in`=32'h76543210, `digit_en`=FF, wait one frame → in slot k, `anode` is 8'hFF for 3 cycles, then ~(1<<k) for 5 cycles, with `nibble`=k. The pattern repeats every 64 cycles.
- **Snapshot:** change `digits_in` to 32'hFFFFFFFF during slot 3 → `nibble` stays at the old values through slot 7. It reads F from slot 0 of the next frame. `frame_start` is high for exactly 1 cycle every 64.
- **Enable/dp:** `digit_en`=8'b1010_0101, `dp_in`=8'h01 → disabled digits keep `anode`=FF for the whole slot. `dp`=1 only during digit 0's lit cycles.
- **Blink** (macro defined): `blink_mask`=8'h80 → digit 7 lit for 2 frames, dark for 2, and so on. Other digits are unaffected. Without the macro, digit 7 is lit every frame.
- **Boundary:** DIV=3, BLANK=1 → each digit is lit for exactly 1 cycle per slot. At most one `anode` bit is ever low; check with an assertion across 1000 frames.
